// File: rtl/intr_source_ctrl.sv
// Machine interrupt source: N_EXT edge-triggered external lines plus an optional machine timer.
// Define INTR_TIMER_EN to build mtime/mtimecmp and the timer source (bit0 of ENABLE/PENDING).
module intr_source_ctrl #(
  parameter int unsigned N_EXT   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_EXT-1:0] ext_irq_i,
  input  logic             sel_i,
  input  logic             we_i,
  input  logic [3:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             intrrupt_o,
  input  logic             intr_ack_i,
  output logic [31:0]      intr_cause_o,
  output logic [2:0]       intr_id_o
);
  localparam logic [31:0] CauseTimer = 32'h8000_0007;
  localparam logic [31:0] CauseExt   = 32'h8000_000B;

  typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             irq_q, irq_d;
  logic [31:0]      cause_q, cause_d;
  logic [2:0]       id_q, id_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [N_EXT:0]   enable_q, enable_d;
  logic [N_EXT-1:0] sync1_q, sync2_q, prev_q, rise_q;
  logic [N_EXT-1:0] ext_pend_q, ext_pend_d, w1c, ack_clr;
  logic [N_EXT:0]   active;
  logic             timer_pend, bus_wr, bus_rd, req_found;
  logic [31:0]      req_cause, rd_mtime, rd_mtimecmp;
  logic [2:0]       req_id;
  logic             unused_bits;

  assign bus_wr      = sel_i & we_i;
  assign bus_rd      = sel_i & ~we_i;
  assign unused_bits = ^{wdata_i, addr_i[1:0]};

`ifdef INTR_TIMER_EN
  localparam bit TimerEn = 1'b1;
  logic [31:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;

  // A bus write to MTIME takes precedence over the free-running increment.
  always_comb begin
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    if (bus_wr && addr_i[3:2] == 2'd0) mtime_d = wdata_i;
    if (bus_wr && addr_i[3:2] == 2'd1) mtimecmp_d = wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign timer_pend  = mtime_q >= mtimecmp_q;
  assign rd_mtime    = mtime_q;
  assign rd_mtimecmp = mtimecmp_q;
`else
  localparam bit TimerEn = 1'b0;
  assign timer_pend  = 1'b0;
  assign rd_mtime    = '0;
  assign rd_mtimecmp = '0;
`endif

  // Pending set (registered rise) overrides W1C and ack clears of the same bit.
  always_comb begin
    enable_d = enable_q;
    if (bus_wr && addr_i[3:2] == 2'd2) begin
      enable_d = wdata_i[N_EXT:0] & {{N_EXT{1'b1}}, TimerEn};
    end
    w1c = '0;
    if (bus_wr && addr_i[3:2] == 2'd3) w1c = wdata_i[N_EXT:1];
    ext_pend_d = (ext_pend_q & ~(w1c | ack_clr)) | rise_q;
  end

  assign active = {ext_pend_q, timer_pend} & enable_q;

  always_comb begin
    req_found = active[0];
    req_cause = CauseTimer;
    req_id    = '0;
    for (int i = 0; i < N_EXT; i++) begin
      if (active[i+1] && !(req_found && req_cause == CauseExt)) begin
        req_found = 1'b1;
        req_cause = CauseExt;
        req_id    = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    irq_d   = irq_q;
    cause_d = cause_q;
    id_d    = id_q;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          cause_d = req_cause;
          id_d    = req_id;
          irq_d   = 1'b1;
          state_d = StAssert;
        end
      end
      StAssert: begin
        if (intr_ack_i) begin
          irq_d   = 1'b0;
          hold_d  = 4'(HOLDOFF);
          state_d = StHoldoff;
          for (int i = 0; i < N_EXT; i++) begin
            ack_clr[i] = (cause_q == CauseExt) && (id_q == 3'(i));
          end
        end
      end
      StHoldoff: begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      unique case (addr_i[3:2])
        2'd0: rdata_d = rd_mtime;
        2'd1: rdata_d = rd_mtimecmp;
        2'd2: rdata_d = 32'(enable_q);
        2'd3: rdata_d = 32'({ext_pend_q, timer_pend});
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      irq_q      <= 1'b0;
      cause_q    <= '0;
      id_q       <= '0;
      rdata_q    <= '0;
      enable_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      rise_q     <= '0;
      ext_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      irq_q      <= irq_d;
      cause_q    <= cause_d;
      id_q       <= id_d;
      rdata_q    <= rdata_d;
      enable_q   <= enable_d;
      sync1_q    <= ext_irq_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rise_q     <= sync2_q & ~prev_q;
      ext_pend_q <= ext_pend_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign intrrupt_o   = irq_q;
  assign intr_cause_o = cause_q;
  assign intr_id_o    = id_q;
endmodule

// File: doc/intr_source_ctrl.md
Name: intr_source_ctrl

Overview:
- Machine-level interrupt source for the three-stage core; drives the core's `intrrupt` input and receives the core's trap-taken acknowledge.
- Holds a 32-bit machine timer (mtime/mtimecmp) and N_EXT edge-triggered external lines, with enable and pending registers on a simple word-addressed bus.
- Presents one request at a time with an mcause-style cause code, and holds it stable until the core acknowledges.

Parameters:
- N_EXT, 4, number of external interrupt lines (1..8).
- HOLDOFF, 2, cycles `intrrupt` stays low after an ack before the next request (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ext_irq  in  N_EXT  asynchronous external interrupt lines, rising-edge significant.
- sel  in  1  bus select.
- we  in  1  write enable, qualified by sel.
- addr  in  4  byte address; word aligned (0x0, 0x4, 0x8, 0xC).
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- intrrupt  out  1  interrupt request to the core.
- intr_ack  in  1  one-cycle pulse from the core when the trap is taken.
- intr_cause  out  32  mcause value of the current request.
- intr_id  out  3  external line index of the current request; 0 for timer.

Behaviour:
- Reset (async) values: mtime=0, mtimecmp=0xFFFF_FFFF, enable=0, pending=0, intrrupt=0, intr_cause=0, intr_id=0, rdata=0, FSM=IDLE, synchronizers=0.
- Register map:
  - 0x0 MTIME: RW. Increments by 1 every cycle and wraps 0xFFFF_FFFF->0. A bus write that cycle wins over the increment.
  - 0x4 MTIMECMP: RW.
  - 0x8 ENABLE: RW. bit0 = timer, bits[N_EXT:1] = ext lines. Other bits read 0.
  - 0xC PENDING: bit0 is read-only. bits[N_EXT:1] are write-1-to-clear.
- Read: rdata updates on the edge after sel&!we. Otherwise rdata holds its value.
- Timer pending: level, bit0 = (mtime >= mtimecmp), unsigned. Cleared only by software moving mtimecmp or mtime.
- External pending:
  - Each line passes a 2-flop synchronizer plus a previous-value flop.
  - A rising edge sets the sticky pending bit 3 edges after the first sampling edge that sees it high.
  - Set wins over a simultaneous W1C or ack-clear of the same bit.
- Priority among enabled pending sources: ext[0] highest, then ext[1]..ext[N_EXT-1], timer lowest.
- FSM:
  - IDLE: if any enabled pending source exists, on the next edge latch its cause and id, set intrrupt=1, go to ASSERT.
  - ASSERT: intrrupt, intr_cause and intr_id held stable, even if enable or pending changes. On intr_ack=1, the next edge sets intrrupt=0, clears the latched external pending bit (timer bit unaffected), loads the holdoff counter=HOLDOFF, and goes to HOLDOFF.
  - HOLDOFF: counter decrements each cycle; on reaching 0, go to IDLE. intrrupt=0 throughout.
- Cause encoding:
  - Timer: 0x8000_0007.
  - External: 0x8000_000B.
  - intr_cause and intr_id keep their last values after deassert.
- intr_ack outside ASSERT is ignored.
- Reset asserted mid-request: intrrupt drops immediately (async) and all state returns to reset values.

Optional Feature:
- Macro: INTR_TIMER_EN.
- Defined: mtime/mtimecmp and the timer source are present as specified above.
- Undefined:
  - No timer logic.
  - Addresses 0x0 and 0x4 read 0 and ignore writes.
  - PENDING bit0 and ENABLE bit0 are tied to 0.
  - Only external causes are produced.

Test Plan:
- Reset; read all four registers -> 0, 0xFFFF_FFFF, 0, 0 (0, 0, 0, 0 without INTR_TIMER_EN); intrrupt=0.
- Enable ext[2] (ENABLE=0x8); pulse ext_irq[2] high for 1 cycle -> PENDING=0x8; intrrupt=1 one edge after pending sets; intr_cause=0x8000_000B, intr_id=2; held until ack. Pulse intr_ack -> intrrupt=0 next edge, PENDING=0, low for 2 cycles before any new request.
- Enable ext[0] and ext[3]; raise both on the same cycle -> id=0 served first; after ack and holdoff, id=3 served.
- Write MTIMECMP=20, ENABLE=0x1, MTIME=0 -> intrrupt rises when mtime reaches 20, with cause 0x8000_0007. After ack the timer request recurs until MTIMECMP is written to 0xFFFF_FFFF.
- Write MTIME=0xFFFF_FFFE -> reads show wrap to 0 after 2 cycles; with MTIMECMP=0xFFFF_FFFF, PENDING bit0 is 1 for exactly one cycle.
- Assert reset while intrrupt=1 -> intrrupt=0 without a clock edge; after release, no request until a new edge or timer match.
